// File: rtl/sdram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter_pkg
// Description : Arbiter ownership states and the SPI write-data filler value.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arbiter_pkg;

  // Port owner: user side, user side draining, SPI side.
  typedef enum logic [1:0] {
    ARB_USER  = 2'd0,
    ARB_DRAIN = 2'd1,
    ARB_SPI   = 2'd2
  } arb_state_t;

  // Recognisable write-data filler shown while SPI (read-only) owns the port.
  localparam logic [15:0] SPI_FILLER = 16'hDEAD;

endpackage
`default_nettype wire

// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter_if
// Description : Bundles the SPI requester, user requester and sdram_ctrl
//               port signals that pass through the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
);
  // SPI flash emulator side
  logic                  spi_critical;
  logic                  spi_refresh_inhibit;
  logic [ADDR_WIDTH-1:0] spi_addr;
  logic                  spi_enable;
  logic                  spi_grant;
  logic                  spi_ack;
  // User command parser side
  logic [ADDR_WIDTH-1:0] user_addr;
  logic                  user_we;
  logic [DATA_WIDTH-1:0] user_wr_data;
  logic [1:0]            user_wr_mask;
  logic                  user_enable;
  logic                  user_ack;
  logic                  user_idle;
  // sdram_ctrl side
  logic [ADDR_WIDTH-1:0] sd_addr;
  logic                  sd_we;
  logic [DATA_WIDTH-1:0] sd_wr_data;
  logic [1:0]            sd_wr_mask;
  logic                  sd_enable;
  logic                  sd_refresh_inhibit;
  logic                  sd_ack_level;
  logic                  sd_idle;
  // Status
  logic [7:0]            drain_errors;

  // Environment view: requesters and controller.
  modport master (
    output spi_critical, spi_refresh_inhibit, spi_addr, spi_enable,
    output user_addr, user_we, user_wr_data, user_wr_mask, user_enable,
    output sd_ack_level, sd_idle,
    input  spi_grant, spi_ack, user_ack, user_idle,
    input  sd_addr, sd_we, sd_wr_data, sd_wr_mask, sd_enable, sd_refresh_inhibit,
    input  drain_errors
  );

  // Arbiter view.
  modport slave (
    input  spi_critical, spi_refresh_inhibit, spi_addr, spi_enable,
    input  user_addr, user_we, user_wr_data, user_wr_mask, user_enable,
    input  sd_ack_level, sd_idle,
    output spi_grant, spi_ack, user_ack, user_idle,
    output sd_addr, sd_we, sd_wr_data, sd_wr_mask, sd_enable, sd_refresh_inhibit,
    output drain_errors
  );
endinterface
`default_nettype wire

// File: rtl/sdram_ack_edge.sv
`default_nettype none
// ============================================================================
// Module      : sdram_ack_edge
// Description : Converts the controller ack level into a one-cycle pulse and
//               tracks whether the ack level has been seen low since the last
//               ownership change, so a new owner is not served a stale ack.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_ack_edge (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic ack_level,
  input  wire logic restart,     // ownership changes at the coming edge
  output logic      ack_pulse,
  output logic      ack_low_ok   // safe to forward a request this cycle
);
  logic ack_prev;
  logic low_seen;

  // Previous ack level and the "ack low seen" flag, re-armed on restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_prev <= 1'b0;
      low_seen <= 1'b1;
    end else begin
      ack_prev <= ack_level;
      if (restart)
        low_seen <= !ack_level;
      else if (!ack_level)
        low_seen <= 1'b1;
    end
  end

  assign ack_pulse  = ack_level && !ack_prev;
  assign ack_low_ok = low_seen || !ack_level;
endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Shares the sdram_ctrl port between the SPI flash read path
//               (priority) and the user command parser. A user access already
//               issued drains before SPI takes over, bounded by a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 16,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  wire logic     clk,
  input  wire logic     reset,
  sdram_arbiter_if.slave bus
);
  localparam int CW = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);

  arb_state_t            state, state_next;
  logic [CW-1:0]         drain_cnt;
  logic                  user_inflight;
  logic [7:0]            drain_errors;
  logic                  ack_pulse;
  logic                  ack_low_ok;
  logic                  restart;
  logic                  user_busy;
  logic                  timeout;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] data_mux;

  sdram_ack_edge u_ack_edge (
    .clk        (clk),
    .reset      (reset),
    .ack_level  (bus.sd_ack_level),
    .restart    (restart),
    .ack_pulse  (ack_pulse),
    .ack_low_ok (ack_low_ok)
  );

  // A request forwarded this cycle already counts as in flight, unless its
  // ack arrives in the same cycle.
  assign user_busy = (user_inflight || (bus.user_enable && ack_low_ok)) && !ack_pulse;
  assign timeout   = (state == ARB_DRAIN) && !ack_pulse && bus.spi_critical &&
                     (drain_cnt == DRAIN_LAST);
  assign restart   = (state == ARB_SPI) != (state_next == ARB_SPI);

  // State register, drain counter, in-flight tracking and error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARB_USER;
      drain_cnt     <= '0;
      user_inflight <= 1'b0;
      drain_errors  <= 8'd0;
    end else begin
      state <= state_next;
      if (state != ARB_DRAIN)
        drain_cnt <= '0;
      else
        drain_cnt <= drain_cnt + 1'b1;
      case (state)
        ARB_USER: begin
          if (ack_pulse)
            user_inflight <= 1'b0;
          else if (bus.user_enable)
            user_inflight <= 1'b1;
        end
        ARB_DRAIN: begin
          if (ack_pulse || timeout)
            user_inflight <= 1'b0;
        end
        default: ;
      endcase
      if (timeout && drain_errors != 8'hFF)
        drain_errors <= drain_errors + 8'd1;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      ARB_USER: begin
        if (bus.spi_critical)
          state_next = user_busy ? ARB_DRAIN : ARB_SPI;
      end
      ARB_DRAIN: begin
        if (ack_pulse)
          state_next = bus.spi_critical ? ARB_SPI : ARB_USER;
        else if (!bus.spi_critical)
          state_next = ARB_USER;
        else if (timeout)
          state_next = ARB_SPI;
      end
      ARB_SPI: begin
        if (!bus.spi_critical && !bus.sd_ack_level && !bus.spi_enable)
          state_next = ARB_USER;
      end
      default: state_next = ARB_USER;
    endcase
  end

  // Output muxes, combinational from the registered owner.
  always_comb begin
    addr_mux               = bus.user_addr;
    data_mux               = bus.user_wr_data;
    bus.sd_we              = bus.user_we;
    bus.sd_wr_mask         = bus.user_wr_mask;
    bus.sd_enable          = bus.user_enable && ack_low_ok;
    bus.sd_refresh_inhibit = 1'b0;
    bus.spi_grant          = 1'b0;
    bus.spi_ack            = 1'b0;
    bus.user_ack           = ack_pulse;
    bus.user_idle          = (state == ARB_USER) ? bus.sd_idle : 1'b0;
    if (state == ARB_SPI) begin
      addr_mux               = bus.spi_addr;
      data_mux               = DATA_WIDTH'(SPI_FILLER);
      bus.sd_we              = 1'b0;
      bus.sd_wr_mask         = 2'b00;
      bus.sd_enable          = bus.spi_enable && ack_low_ok;
      bus.sd_refresh_inhibit = bus.spi_refresh_inhibit;
      bus.spi_grant          = 1'b1;
      bus.spi_ack            = ack_pulse;
      bus.user_ack           = 1'b0;
    end
  end

  assign bus.sd_addr      = addr_mux;
  assign bus.sd_wr_data   = data_mux;
  assign bus.drain_errors = drain_errors;
endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Directed self-checking bench for sdram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sdram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) bus ();

  sdram_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(16), .DRAIN_TIMEOUT(64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.spi_critical = 0; bus.spi_refresh_inhibit = 0; bus.spi_addr = 0; bus.spi_enable = 0;
    bus.user_addr = 0; bus.user_we = 0; bus.user_wr_data = 0; bus.user_wr_mask = 0;
    bus.user_enable = 0; bus.sd_ack_level = 0; bus.sd_idle = 1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.spi_grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0", bus.spi_grant); end
    checks++; if (bus.spi_ack !== 1'b0) begin errors++; $display("FAIL reset_spi_ack: got %b expected 0", bus.spi_ack); end
    checks++; if (bus.user_ack !== 1'b0) begin errors++; $display("FAIL reset_user_ack: got %b expected 0", bus.user_ack); end
    checks++; if (bus.sd_enable !== 1'b0) begin errors++; $display("FAIL reset_sd_enable: got %b expected 0", bus.sd_enable); end
    checks++; if (bus.sd_refresh_inhibit !== 1'b0) begin errors++; $display("FAIL reset_refresh: got %b expected 0", bus.sd_refresh_inhibit); end
    checks++; if (bus.drain_errors !== 8'd0) begin errors++; $display("FAIL reset_drain_errors: got %0d expected 0", bus.drain_errors); end
  endtask

  task automatic test_user_write();
    int pulses;
    bus.user_addr = 32'h100; bus.user_we = 1; bus.user_wr_data = 16'hBEEF;
    bus.user_wr_mask = 2'b11; bus.user_enable = 1;
    #1;
    checks++; if (bus.sd_enable !== 1'b1) begin errors++; $display("FAIL uw_enable: got %b expected 1", bus.sd_enable); end
    checks++; if (bus.sd_we !== 1'b1) begin errors++; $display("FAIL uw_we: got %b expected 1", bus.sd_we); end
    checks++; if (bus.sd_addr !== 32'h100) begin errors++; $display("FAIL uw_addr: got 0x%0h expected 0x100", bus.sd_addr); end
    checks++; if (bus.sd_wr_data !== 16'hBEEF) begin errors++; $display("FAIL uw_data: got 0x%0h expected 0xbeef", bus.sd_wr_data); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.user_ack === 1'b1) pulses++;
    end
    bus.sd_ack_level = 1; #1;
    if (bus.user_ack === 1'b1) pulses++;
    tick();
    if (bus.user_ack === 1'b1) pulses++;
    bus.user_enable = 0; bus.sd_ack_level = 0; #1;
    checks++; if (pulses != 1) begin errors++; $display("FAIL uw_ack_pulses: got %0d expected 1", pulses); end
    checks++; if (bus.sd_enable !== 1'b0) begin errors++; $display("FAIL uw_enable_drop: got %b expected 0", bus.sd_enable); end
    checks++; if (bus.spi_grant !== 1'b0) begin errors++; $display("FAIL uw_grant: got %b expected 0", bus.spi_grant); end
    bus.user_we = 0;
    tick();
  endtask

  task automatic test_spi_read();
    bus.spi_critical = 1; #1;
    checks++; if (bus.spi_grant !== 1'b0) begin errors++; $display("FAIL sr_grant_early: got %b expected 0", bus.spi_grant); end
    tick();
    checks++; if (bus.spi_grant !== 1'b1) begin errors++; $display("FAIL sr_grant: got %b expected 1", bus.spi_grant); end
    bus.user_enable = 1; bus.user_addr = 32'h200; bus.user_we = 1;
    bus.spi_addr = 32'h10; bus.spi_enable = 1; #1;
    checks++; if (bus.sd_addr !== 32'h10) begin errors++; $display("FAIL sr_addr: got 0x%0h expected 0x10", bus.sd_addr); end
    checks++; if (bus.sd_we !== 1'b0) begin errors++; $display("FAIL sr_we: got %b expected 0", bus.sd_we); end
    checks++; if (bus.sd_wr_data !== 16'hDEAD) begin errors++; $display("FAIL sr_filler: got 0x%0h expected 0xdead", bus.sd_wr_data); end
    checks++; if (bus.sd_enable !== 1'b1) begin errors++; $display("FAIL sr_enable: got %b expected 1", bus.sd_enable); end
    tick(); tick();
    bus.sd_ack_level = 1; #1;
    checks++; if (bus.spi_ack !== 1'b1) begin errors++; $display("FAIL sr_spi_ack: got %b expected 1", bus.spi_ack); end
    checks++; if (bus.user_ack !== 1'b0) begin errors++; $display("FAIL sr_user_ack: got %b expected 0", bus.user_ack); end
    tick();
    checks++; if (bus.spi_ack !== 1'b0) begin errors++; $display("FAIL sr_spi_ack_once: got %b expected 0", bus.spi_ack); end
    bus.spi_enable = 0; bus.sd_ack_level = 0; bus.spi_critical = 0; bus.user_enable = 0; bus.user_we = 0;
    tick();
    checks++; if (bus.spi_grant !== 1'b0) begin errors++; $display("FAIL sr_release: got %b expected 0", bus.spi_grant); end
    tick();
  endtask

  task automatic test_drain();
    bus.user_addr = 32'h300; bus.user_we = 0; bus.user_enable = 1;
    tick();
    bus.spi_critical = 1;
    tick();
    checks++; if (bus.spi_grant !== 1'b0) begin errors++; $display("FAIL dr_grant: got %b expected 0", bus.spi_grant); end
    checks++; if (bus.sd_addr !== 32'h300) begin errors++; $display("FAIL dr_addr: got 0x%0h expected 0x300", bus.sd_addr); end
    checks++; if (bus.user_idle !== 1'b0) begin errors++; $display("FAIL dr_idle: got %b expected 0", bus.user_idle); end
    for (int i = 0; i < 4; i++) tick();
    bus.sd_ack_level = 1; #1;
    checks++; if (bus.user_ack !== 1'b1) begin errors++; $display("FAIL dr_user_ack: got %b expected 1", bus.user_ack); end
    checks++; if (bus.spi_grant !== 1'b0) begin errors++; $display("FAIL dr_grant_late: got %b expected 0", bus.spi_grant); end
    tick();
    bus.spi_addr = 32'h44; bus.spi_enable = 1; #1;
    checks++; if (bus.spi_grant !== 1'b1) begin errors++; $display("FAIL dr_grant_after: got %b expected 1", bus.spi_grant); end
    checks++; if (bus.user_ack !== 1'b0) begin errors++; $display("FAIL dr_user_ack_once: got %b expected 0", bus.user_ack); end
    checks++; if (bus.sd_enable !== 1'b0) begin errors++; $display("FAIL dr_stale_ack_gate: got %b expected 0", bus.sd_enable); end
    bus.user_enable = 0; bus.sd_ack_level = 0; #1;
    checks++; if (bus.sd_enable !== 1'b1) begin errors++; $display("FAIL dr_forward: got %b expected 1", bus.sd_enable); end
    checks++; if (bus.drain_errors !== 8'd0) begin errors++; $display("FAIL dr_errors: got %0d expected 0", bus.drain_errors); end
    bus.spi_enable = 0; bus.spi_critical = 0;
    tick(); tick();
  endtask

  task automatic test_spi_outstanding();
    bus.spi_critical = 1;
    tick();
    bus.spi_refresh_inhibit = 1; bus.spi_addr = 32'h20; bus.spi_enable = 1; #1;
    checks++; if (bus.sd_refresh_inhibit !== 1'b1) begin errors++; $display("FAIL so_refresh_spi: got %b expected 1", bus.sd_refresh_inhibit); end
    tick();
    bus.spi_critical = 0;
    tick();
    checks++; if (bus.spi_grant !== 1'b1) begin errors++; $display("FAIL so_hold: got %b expected 1", bus.spi_grant); end
    bus.sd_ack_level = 1; #1;
    checks++; if (bus.spi_ack !== 1'b1) begin errors++; $display("FAIL so_ack: got %b expected 1", bus.spi_ack); end
    tick();
    bus.spi_enable = 0;
    tick();
    checks++; if (bus.spi_grant !== 1'b1) begin errors++; $display("FAIL so_ack_high_hold: got %b expected 1", bus.spi_grant); end
    bus.sd_ack_level = 0;
    tick();
    checks++; if (bus.spi_grant !== 1'b0) begin errors++; $display("FAIL so_release: got %b expected 0", bus.spi_grant); end
    checks++; if (bus.sd_refresh_inhibit !== 1'b0) begin errors++; $display("FAIL so_refresh_user: got %b expected 0", bus.sd_refresh_inhibit); end
    bus.spi_refresh_inhibit = 0;
    tick();
  endtask

  task automatic test_timeout();
    int  edges;
    int  saw_ack;
    logic timed_out;
    saw_ack = 0; timed_out = 0;
    bus.user_addr = 32'h400; bus.user_enable = 1;
    tick();
    bus.spi_critical = 1;
    edges = 0;
    while (bus.spi_grant !== 1'b1 && edges < 100) begin
      tick();
      edges++;
      if (bus.user_ack === 1'b1) saw_ack++;
    end
    checks++; if (edges != 65) begin errors++; $display("FAIL to_latency: got %0d edges expected 65", edges); end
    checks++; if (bus.drain_errors !== 8'd1) begin errors++; $display("FAIL to_errors_1: got %0d expected 1", bus.drain_errors); end
    for (int n = 0; n < 299; n++) begin
      bus.spi_critical = 0;
      tick();
      tick();
      bus.spi_critical = 1;
      edges = 0;
      while (bus.spi_grant !== 1'b1 && edges < 100) begin
        tick();
        edges++;
        if (bus.user_ack === 1'b1) saw_ack++;
      end
      if (edges >= 100) timed_out = 1;
    end
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL to_loop_bound: got %b expected 0", timed_out); end
    checks++; if (bus.drain_errors !== 8'd255) begin errors++; $display("FAIL to_saturate: got %0d expected 255", bus.drain_errors); end
    checks++; if (saw_ack != 0) begin errors++; $display("FAIL to_no_user_ack: got %0d expected 0", saw_ack); end
  endtask

  task automatic test_reset_drain();
    bus.spi_critical = 0;
    tick(); tick();
    bus.spi_critical = 1;
    tick(); tick();
    checks++; if (bus.spi_grant !== 1'b0) begin errors++; $display("FAIL rd_in_drain: got %b expected 0", bus.spi_grant); end
    reset = 1; bus.user_enable = 0; bus.spi_critical = 0; bus.sd_ack_level = 0; bus.sd_idle = 1;
    tick();
    checks++; if (bus.spi_grant !== 1'b0) begin errors++; $display("FAIL rd_grant: got %b expected 0", bus.spi_grant); end
    checks++; if ((bus.spi_ack | bus.user_ack) !== 1'b0) begin errors++; $display("FAIL rd_acks: got %b expected 0", bus.spi_ack | bus.user_ack); end
    checks++; if (bus.sd_enable !== 1'b0) begin errors++; $display("FAIL rd_enable: got %b expected 0", bus.sd_enable); end
    checks++; if (bus.drain_errors !== 8'd0) begin errors++; $display("FAIL rd_errors: got %0d expected 0", bus.drain_errors); end
    checks++; if (bus.user_idle !== 1'b1) begin errors++; $display("FAIL rd_user_idle: got %b expected 1", bus.user_idle); end
    reset = 0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_user_write();
    test_spi_read();
    test_drain();
    test_spi_outstanding();
    test_timeout();
    test_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
